mem_access_unit: RTL and testbench

Sequential, parametrised memory-access stage that executes LDR (opcode 1001) and STR (1010) against a synchronous RAM with a configurable number of wait states. It sits between the execute stage and data RAM, replacing the purely combinational LDR/STR steering. It adds a valid/ready request handshake, registered RAM address/data, a completion pulse, and a held load-result register. Non-memory opcodes pass through with no RAM activity.

---
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: executes LDR/STR against a synchronous RAM, passes other opcodes through.
// Latency: LDR/STR done WAIT_CYCLES+2 cycles after acceptance; non-memory ops done 1 cycle after.
// Backpressure: req_ready low while a RAM access is in flight; requester holds req_valid until accepted.
module mem_access_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        op_code,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              done,
   output logic              ldr_valid,
   output logic [DATA_W-1:0] ldr_data,
   output logic              sel_ldr_bus,
   output logic              sel_add_bus,
   output logic              busy
);

   localparam logic [3:0] OP_LDR = 4'b1001;
   localparam logic [3:0] OP_STR = 4'b1010;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_ldr_data;

   logic w_ready;
   logic w_accept;
   logic w_is_mem;
   logic w_last;
   logic w_unused_src1;

   assign w_accept = req_valid && w_ready;
   assign w_is_mem = (op_code == OP_LDR) || (op_code == OP_STR);
   assign w_last   = (r_cnt == 4'd0);
   // Only the low ADDR_W bits of src1 address the RAM; the rest is deliberately ignored.
   assign w_unused_src1 = ^src1;

   // State register; async reset drops any in-flight access immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and output decode; all outputs are pure functions of the registered state.
   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      sel_add_bus = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      ldr_valid   = 1'b0;
      sel_ldr_bus = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_ready = 1'b1;
            if (r_state == S_DONE) begin
               done        = 1'b1;
               ldr_valid   = (r_op == OP_LDR);
               sel_ldr_bus = (r_op == OP_LDR);
            end
            if (w_accept) w_next = w_is_mem ? S_ACCESS : S_DONE;
            else          w_next = S_IDLE;
         end
         S_ACCESS: begin
            ram_en      = 1'b1;
            sel_add_bus = 1'b1;
            busy        = 1'b1;
            ram_we      = (r_op == OP_STR);
            if (w_last) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, wait counter and load-result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 4'd0;
         r_op       <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ldr_data <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= op_code;
            r_addr  <= src1[ADDR_W-1:0];
            r_wdata <= src2;
            if (w_is_mem) r_cnt <= 4'(WAIT_CYCLES);
         end else if (r_state == S_ACCESS) begin
            if (!w_last) begin
               r_cnt <= r_cnt - 4'd1;
            end else if (r_op == OP_LDR) begin
               r_ldr_data <= ram_rdata;
            end
         end
      end
   end

   assign req_ready = w_ready;
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign ldr_data  = r_ldr_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (32/16/W1, 64/20/W0, 64/20/W4) with RAM models.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen high.
module tb_mem_access_unit;

   localparam logic [3:0] LDR = 4'b1001;
   localparam logic [3:0] STR = 4'b1010;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   int          sel = 0;
   logic [3:0]  op = 4'd0;
   logic [63:0] src1 = '0;
   logic [63:0] src2 = '0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Per-instance outputs gathered into arrays so tasks can index them.
   logic        o_rdy[3], o_en[3], o_we[3], o_done[3], o_lv[3], o_sldr[3], o_sadd[3], o_busy[3];
   logic [63:0] o_addr[3], o_wdata[3], o_ldata[3], rdata[3];
   logic [63:0] mem[3][256];

   logic [15:0] addr0;
   logic [31:0] wdata0, ldata0;
   logic [19:0] addr1, addr2;

   mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(1)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 0), .req_ready(o_rdy[0]),
      .op_code(op), .src1(src1[31:0]), .src2(src2[31:0]),
      .ram_en(o_en[0]), .ram_we(o_we[0]), .ram_addr(addr0), .ram_wdata(wdata0),
      .ram_rdata(rdata[0][31:0]), .done(o_done[0]), .ldr_valid(o_lv[0]), .ldr_data(ldata0),
      .sel_ldr_bus(o_sldr[0]), .sel_add_bus(o_sadd[0]), .busy(o_busy[0]));

   mem_access_unit #(.DATA_W(64), .ADDR_W(20), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 1), .req_ready(o_rdy[1]),
      .op_code(op), .src1(src1), .src2(src2),
      .ram_en(o_en[1]), .ram_we(o_we[1]), .ram_addr(addr1), .ram_wdata(o_wdata[1]),
      .ram_rdata(rdata[1]), .done(o_done[1]), .ldr_valid(o_lv[1]), .ldr_data(o_ldata[1]),
      .sel_ldr_bus(o_sldr[1]), .sel_add_bus(o_sadd[1]), .busy(o_busy[1]));

   mem_access_unit #(.DATA_W(64), .ADDR_W(20), .WAIT_CYCLES(4)) u2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2), .req_ready(o_rdy[2]),
      .op_code(op), .src1(src1), .src2(src2),
      .ram_en(o_en[2]), .ram_we(o_we[2]), .ram_addr(addr2), .ram_wdata(o_wdata[2]),
      .ram_rdata(rdata[2]), .done(o_done[2]), .ldr_valid(o_lv[2]), .ldr_data(o_ldata[2]),
      .sel_ldr_bus(o_sldr[2]), .sel_add_bus(o_sadd[2]), .busy(o_busy[2]));

   assign o_addr[0]  = {48'd0, addr0};
   assign o_wdata[0] = {32'd0, wdata0};
   assign o_ldata[0] = {32'd0, ldata0};
   assign o_addr[1]  = {44'd0, addr1};
   assign o_addr[2]  = {44'd0, addr2};

   // RAM models: synchronous write, combinational read, indexed by the low address byte.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) mem[k][i] <= '0;
      end else begin
         for (int k = 0; k < 3; k++)
            if (o_en[k] && o_we[k]) mem[k][o_addr[k][7:0]] <= o_wdata[k];
      end
   end
   assign rdata[0] = mem[0][o_addr[0][7:0]];
   assign rdata[1] = mem[1][o_addr[1][7:0]];
   assign rdata[2] = mem[2][o_addr[2][7:0]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          s;
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] d;
      int          lat;
      logic        we;
      logic [63:0] addr;
      logic        lv;
      logic [63:0] ld;
   } vec_t;

   // Issue one request on instance v.s and check the access window and completion.
   task automatic run_vec(input int idx, input vec_t v);
      int  c, en_cnt, done_c;
      bit  bad;
      logic lv_s, sl_s;
      logic [63:0] ld_s;
      en_cnt = 0; done_c = 0; bad = 0; lv_s = 0; sl_s = 0; ld_s = '0;
      @(negedge clk);
      for (int i = 0; i < 20 && !o_rdy[v.s]; i++) @(negedge clk);
      chk($sformatf("v%0d_ready", idx), 64'(o_rdy[v.s]), 64'd1);
      sel = v.s; op = v.op; src1 = v.a; src2 = v.d; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (c = 1; c <= 20; c++) begin
         if (o_done[v.s]) begin
            done_c = c; lv_s = o_lv[v.s]; sl_s = o_sldr[v.s]; ld_s = o_ldata[v.s];
            break;
         end
         if (o_en[v.s]) begin
            en_cnt++;
            if (o_we[v.s] !== v.we || o_addr[v.s] !== v.addr || o_wdata[v.s] !== v.d ||
                o_sadd[v.s] !== 1'b1 || o_busy[v.s] !== 1'b1 || o_rdy[v.s] !== 1'b0) bad = 1;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_latency", idx), 64'(done_c), 64'(v.lat));
      chk($sformatf("v%0d_en_cycles", idx), 64'(en_cnt), 64'(v.lat == 1 ? 0 : v.lat - 1));
      chk($sformatf("v%0d_access_bus", idx), 64'(bad), 64'd0);
      chk($sformatf("v%0d_ldr_valid", idx), {62'd0, lv_s, sl_s}, {62'd0, v.lv, v.lv});
      chk($sformatf("v%0d_ldr_data", idx), ld_s, v.ld);
   endtask

   vec_t vt[12];

   initial begin
      int acc[3];
      int k, ndone, nlv;
      bit rdy_bad;
      logic [3:0]  bop[3];
      logic [63:0] ba[3];

      vt[0]  = '{0, STR,   64'h10, 64'hDEAD_BEEF, 3, 1'b1, 64'h10, 1'b0, 64'h0};
      vt[1]  = '{0, LDR,   64'h10, 64'h0,         3, 1'b0, 64'h10, 1'b1, 64'hDEAD_BEEF};
      vt[2]  = '{0, 4'h0,  64'h20, 64'h0,         1, 1'b0, 64'h0,  1'b0, 64'hDEAD_BEEF};
      vt[3]  = '{0, STR,   64'h3,  64'h1234_5678, 3, 1'b1, 64'h3,  1'b0, 64'hDEAD_BEEF};
      vt[4]  = '{0, LDR,   64'h3,  64'h0,         3, 1'b0, 64'h3,  1'b1, 64'h1234_5678};
      vt[5]  = '{0, LDR,   64'h5,  64'h0,         3, 1'b0, 64'h5,  1'b1, 64'h0};
      vt[6]  = '{1, STR,   64'hFFFF_FFFF_FFF1_2345, 64'h0123_4567_89AB_CDEF, 2, 1'b1, 64'h12345, 1'b0, 64'h0};
      vt[7]  = '{1, LDR,   64'hFFFF_FFFF_FFF1_2345, 64'h0,                   2, 1'b0, 64'h12345, 1'b1, 64'h0123_4567_89AB_CDEF};
      vt[8]  = '{1, 4'h0,  64'h0,                 64'h0,                   1, 1'b0, 64'h0,     1'b0, 64'h0123_4567_89AB_CDEF};
      vt[9]  = '{2, STR,   64'hFFFF_FFFF_FFF1_2345, 64'hCAFE_F00D_5555_AAAA, 6, 1'b1, 64'h12345, 1'b0, 64'h0};
      vt[10] = '{2, LDR,   64'hFFFF_FFFF_FFF1_2345, 64'h0,                   6, 1'b0, 64'h12345, 1'b1, 64'hCAFE_F00D_5555_AAAA};
      vt[11] = '{2, 4'h7,  64'h0,                 64'h0,                   1, 1'b0, 64'h0,     1'b0, 64'hCAFE_F00D_5555_AAAA};

      // Reset values on every instance.
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_bits%0d", i),
             {56'd0, o_rdy[i], o_en[i], o_we[i], o_done[i], o_lv[i], o_sldr[i], o_sadd[i], o_busy[i]},
             64'h80);
         chk($sformatf("rst_regs%0d", i), o_addr[i] | o_wdata[i] | o_ldata[i], 64'h0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

      // Load result is held long after the completion pulse.
      run_vec(12, '{0, LDR, 64'h10, 64'h0, 3, 1'b0, 64'h10, 1'b1, 64'hDEAD_BEEF});
      repeat (10) @(negedge clk);
      chk("hold_ldr_data", o_ldata[0], 64'hDEAD_BEEF);
      chk("hold_ldr_valid", 64'(o_lv[0]), 64'd0);

      // Back-to-back LDR, LDR, STR with req_valid held high.
      bop[0] = LDR; ba[0] = 64'h10;
      bop[1] = LDR; ba[1] = 64'h3;
      bop[2] = STR; ba[2] = 64'h7;
      k = 0; ndone = 0; nlv = 0; rdy_bad = 0;
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      sel = 0; src2 = 64'h7777_0000;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (o_done[0]) ndone++;
         if (o_lv[0]) nlv++;
         if (o_busy[0] && o_rdy[0]) rdy_bad = 1;
         if (o_rdy[0]) begin
            if (k < 3) begin
               op = bop[k]; src1 = ba[k]; req_valid = 1'b1; acc[k] = c; k++;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 64'(k), 64'd3);
      chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'd3);
      chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'd3);
      chk("b2b_done_pulses", 64'(ndone), 64'd3);
      chk("b2b_ldr_pulses", 64'(nlv), 64'd2);
      chk("b2b_ready_in_access", 64'(rdy_bad), 64'd0);
      chk("b2b_ldr_data", o_ldata[0], 64'h1234_5678);

      // Reset asserted during the second ACCESS cycle of a STR.
      @(negedge clk);
      sel = 0; op = STR; src1 = 64'h44; src2 = 64'h5A5A_5A5A; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_first_access", {62'd0, o_en[0], o_we[0]}, 64'h3);
      @(negedge clk);
      chk("mid_second_access", {62'd0, o_en[0], o_we[0]}, 64'h3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_bits",
          {56'd0, o_rdy[0], o_en[0], o_we[0], o_done[0], o_lv[0], o_sldr[0], o_sadd[0], o_busy[0]},
          64'h80);
      chk("mid_rst_regs", o_addr[0] | o_wdata[0] | o_ldata[0], 64'h0);
      ndone = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (o_done[0]) ndone++;
      end
      chk("mid_rst_no_done", 64'(ndone), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
